// File: rtl/eight_add_sequencer.sv
// ---------------------------------------------------------------------------
// eight_add_sequencer
//
// Purpose:
//   Multi-byte adder controller that time-shares a single 8-bit adder
//   (eight_bit_add_module, defined below in this file) between two
//   requesters. A round-robin arbiter picks a requester, the operands are
//   latched, and an 8*NBYTES-bit sum is built one byte at a time, least
//   significant byte first. The shared adder has no carry-in, so the
//   carry into each byte is added by a second pass (INC) through the
//   same adder.
//
// Parameters:
//   NBYTES            operand width in bytes (1..8), default 4
//
// Optional feature macro:
//   EIGHT_ADD_CARRY_SKIP_EN  when defined, the INC pass is skipped for
//                            bytes whose carry-in is 0 (variable latency).
//                            When undefined, every byte takes ADD + INC.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req0/req1  in   add requests, held until the matching grant
//   a0,b0      in   requester 0 operands, sampled on the gnt0 cycle
//   a1,b1      in   requester 1 operands, sampled on the gnt1 cycle
//   gnt0/gnt1  out  one-cycle accept pulse (combinational in IDLE)
//   busy       out  high from the cycle after grant through DONE
//   done       out  one-cycle pulse; result/cout/done_id valid
//   done_id    out  requester owning the completed result
//   result     out  sum, held until the next done
//   cout       out  carry out of the most significant byte
//   fsm_state  out  current state encoding (IDLE=0 ADD=1 INC=2 DONE=3)
//
// Handshake: a requester raises req with its operands stable and keeps
// both until it sees its gnt high; the operands are captured on the clock
// edge that ends the gnt cycle. Dropping req before gnt withdraws it.
// ---------------------------------------------------------------------------

module eight_bit_add_module (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       co
);
    assign {co, sum} = {1'b0, a} + {1'b0, b};
endmodule

module eight_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [8*NBYTES-1:0]   a0,
    input  logic [8*NBYTES-1:0]   b0,
    input  logic                  req1,
    input  logic [8*NBYTES-1:0]   a1,
    input  logic [8*NBYTES-1:0]   b1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic [1:0]            fsm_state
);

    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        INC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Latched operands and running partial sum, viewed as byte arrays.
    logic [NBYTES-1:0][7:0] a_q;
    logic [NBYTES-1:0][7:0] b_q;
    logic [NBYTES-1:0][7:0] partial;
    logic [NBYTES-1:0][7:0] partial_next;

    logic [KW-1:0] k;
    logic [KW-1:0] k_next;
    logic          c;           // carry into byte k
    logic          c_next;
    logic          co_add_r;    // carry out of the ADD pass of byte k
    logic          co_add_next;
    logic          id_q;
    logic          last_gnt;

    // Arbitration.
    logic any_req;
    logic pick_id;

    // Shared adder.
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [7:0] add_sum;
    logic       add_co;

    eight_bit_add_module u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .co  (add_co)
    );

    // -----------------------------------------------------------------------
    // Round-robin pick: a lone requester wins; on a tie the requester that
    // did not win last time wins. last_gnt resets to 1 so req0 wins the
    // first tie.
    // -----------------------------------------------------------------------
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            pick_id = ~last_gnt;
        end else begin
            pick_id = req1;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ADD;
                end
            end
            ADD: begin
`ifdef EIGHT_ADD_CARRY_SKIP_EN
                // With no carry into this byte the ADD result is final.
                if (!c) begin
                    state_next = (k == K_LAST) ? DONE : ADD;
                end else begin
                    state_next = INC;
                end
`else
                state_next = INC;
`endif
            end
            INC: begin
                state_next = (k == K_LAST) ? DONE : ADD;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs decoded from state
    // -----------------------------------------------------------------------
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        fsm_state = state;
        case (state)
            IDLE: begin
                // Grant is suppressed while reset is asserted so no accept
                // pulse is seen for an operation that will not be captured.
                gnt0 = any_req & ~pick_id & ~rst;
                gnt1 = any_req &  pick_id & ~rst;
            end
            ADD, INC: begin
                busy = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Adder input mux: ADD adds operand bytes, INC adds the pending carry
    // to the partial byte.
    // -----------------------------------------------------------------------
    always_comb begin
        add_a = a_q[k];
        add_b = b_q[k];
        if (state == INC) begin
            add_a = partial[k];
            add_b = {7'b0, c};
        end
    end

    // -----------------------------------------------------------------------
    // Datapath next values for the ADD/INC steps.
    // -----------------------------------------------------------------------
    always_comb begin
        partial_next = partial;
        k_next       = k;
        c_next       = c;
        co_add_next  = co_add_r;
        case (state)
            ADD: begin
                partial_next[k] = add_sum;
                co_add_next     = add_co;
`ifdef EIGHT_ADD_CARRY_SKIP_EN
                if (!c) begin
                    c_next = add_co;
                    if (k != K_LAST) begin
                        k_next = k + K_ONE;
                    end
                end
`endif
            end
            INC: begin
                partial_next[k] = add_sum;
                // A byte sum plus a carry can only overflow if the ADD
                // pass did not, so the two carries never coincide.
                c_next = co_add_r | add_co;
                if (k != K_LAST) begin
                    k_next = k + K_ONE;
                end
            end
            default: begin
                partial_next = partial;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers. result/cout/done_id load on the edge entering
    // DONE so they are valid together with the done pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            partial  <= '0;
            k        <= '0;
            c        <= 1'b0;
            co_add_r <= 1'b0;
            id_q     <= 1'b0;
            last_gnt <= 1'b1;
            result   <= '0;
            cout     <= 1'b0;
            done_id  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (any_req) begin
                    a_q      <= pick_id ? a1 : a0;
                    b_q      <= pick_id ? b1 : b0;
                    id_q     <= pick_id;
                    last_gnt <= pick_id;
                    partial  <= '0;
                    k        <= '0;
                    c        <= 1'b0;
                    co_add_r <= 1'b0;
                end
            end else begin
                partial  <= partial_next;
                k        <= k_next;
                c        <= c_next;
                co_add_r <= co_add_next;
            end
            if (state != DONE && state_next == DONE) begin
                result  <= partial_next;
                cout    <= c_next;
                done_id <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_eight_add_sequencer.sv
module tb_eight_add_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, done, done_id, cout;
  logic [W-1:0] result;
  logic [1:0]   fsm_state;

  eight_add_sequencer #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .result    (result),
    .cout      (cout),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard: {done_id, cout, result} and expected done cycle
  logic [W+1:0] exp_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // latency from grant cycle to done cycle
  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef EIGHT_ADD_CARRY_SKIP_EN
    int n;
    logic [8:0] t;
    logic cin;
    n = NB + 1;
    cin = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (cin) n++;
      t = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]} + {8'd0, cin};
      cin = t[8];
    end
    return n;
`else
    return 2 * NB + 1;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst !== 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done result=%0h cout=%0b id=%0b required no done", result, cout, done_id);
      end else begin
        logic [W+1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", 64'(result), 64'(e[W-1:0]));
        check("cout", 64'(cout), 64'(e[W]));
        check("done_id", 64'(done_id), 64'(e[W+1]));
        check("done_cycle", 64'(cyc), 64'(ec));
        check("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] r, input logic co);
    exp_q.push_back({id, co, r});
    exp_cyc_q.push_back(cyc + exp_latency(a, b));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  // single requester add with hand-computed result
  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic co);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; req0 = 1'b1; end
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if ((id ? gnt1 : gnt0) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("grant_seen", 64'(got), 64'd1);
    if (got) begin
      check("other_gnt_low", 64'(id ? gnt0 : gnt1), 64'd0);
      push_exp(id, a, b, r, co);
      @(posedge clk); #1;
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      check("busy_cycle1", 64'(busy), 64'd1);
      wait_drain();
    end else begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  // both requesters held high: grants alternate 0,1,0
  task automatic tie_test();
    logic got;
    logic id;
    int prev_cyc;
    int prev_lat;
    prev_cyc = 0;
    prev_lat = 0;
    @(posedge clk); #1;
    a0 = 32'h1111_1111; b0 = 32'h2222_2222;
    a1 = 32'hF0F0_F0F0; b1 = 32'h0F0F_0F10;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      got = 1'b0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      check("tie_grant_seen", 64'(got), 64'd1);
      if (!got) break;
      id = gnt1;
      check("tie_grant_id", 64'(id), 64'(i % 2));
      check("tie_one_hot", 64'(gnt0 & gnt1), 64'd0);
      if (i > 0) check("tie_spacing", 64'(cyc - prev_cyc), 64'(prev_lat + 1));
      prev_cyc = cyc;
      if (id) begin
        push_exp(1'b1, a1, b1, 32'h0000_0000, 1'b1);
        prev_lat = exp_latency(a1, b1);
      end else begin
        push_exp(1'b0, a0, b0, 32'h3333_3333, 1'b0);
        prev_lat = exp_latency(a0, b0);
      end
      @(posedge clk);
    end
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    wait_drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic got;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_gnt0", 64'(gnt0), 64'd0);
    check("rst_gnt1", 64'(gnt1), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_done_id", 64'(done_id), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_result", 64'(result), 64'd0);

    // directed adds
    issue(1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0);
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    issue(1'b0, 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0);
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
    issue(1'b1, 32'hDEAD_BEEF, 32'h2152_4111, 32'h0000_0000, 1'b1);
    issue(1'b0, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 1'b0);
    issue(1'b0, 32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0);

    // reset in cycle 4 of an operation
    got = 1'b0;
    @(posedge clk); #1;
    a1 = 32'h0F0F_0F0F; b1 = 32'h0101_0101; req1 = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (gnt1 === 1'b1) begin got = 1'b1; break; end
    end
    check("midrst_grant_seen", 64'(got), 64'd1);
    @(posedge clk); #1;                 // cycle 1
    req1 = 1'b0;
    repeat (3) @(posedge clk);          // cycle 4
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    check("midrst_done_id", 64'(done_id), 64'd0);
    check("midrst_gnt0", 64'(gnt0), 64'd0);
    check("midrst_gnt1", 64'(gnt1), 64'd0);
    // the abandoned operation must never produce done
    repeat (12) @(negedge clk);

    // tie / round robin from a freshly reset pointer
    tie_test();

    // idle: nothing moves, last result (requester 0 of the tie) held
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_gnt0", 64'(gnt0), 64'd0);
      check("idle_gnt1", 64'(gnt1), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_result", 64'(result), 64'h3333_3333);
    end

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d required completion before limit", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
